mdu_ctrl: RTL

//  Sequencer for the multiply/divide unit fed by the D/E pipeline register (MDUEN, MDUCtrl).

---
 rtl/mdu_ctrl_if.sv | 30 +++
 rtl/mdu_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: groups the E-stage request, the D-stage hazard input and the
// MDU status/result outputs. The cancel signal exists only when
// MDU_CANCEL_EN is defined.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_mdu_use;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MDU_CANCEL_EN
  modport master (output start, op, a, b, d_mdu_use, cancel,
                  input  busy, stall, done, hi, lo);
  modport slave  (input  start, op, a, b, d_mdu_use, cancel,
                  output busy, stall, done, hi, lo);
`else
  modport master (output start, op, a, b, d_mdu_use,
                  input  busy, stall, done, hi, lo);
  modport slave  (input  start, op, a, b, d_mdu_use,
                  output busy, stall, done, hi, lo);
`endif
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer. Computes the result when the op is
// accepted, holds it in pending registers for a fixed latency, then commits
// to HI/LO and pulses done. Owns HI/LO and generates the F/D stall.
// Optional feature: define MDU_CANCEL_EN to add the cancel input, which
// aborts an in-flight mult/div without touching HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] count_r;
  logic          done_r;
  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic [31:0]   pending_hi_r;
  logic [31:0]   pending_lo_r;

  logic          start_s;
  logic          cancel_s;
  logic          busy_s;
  logic [63:0]   prod_s;
  logic [31:0]   res_hi_s;
  logic [31:0]   res_lo_s;

`ifdef MDU_CANCEL_EN
  // cancel takes priority over a start presented at the same edge
  assign start_s  = bus.start & ~bus.cancel;
  assign cancel_s = bus.cancel;
`else
  assign start_s  = bus.start;
  assign cancel_s = 1'b0;
`endif

  assign busy_s    = (state_r != IDLE);
  assign bus.busy  = busy_s;
  // op<=3 is exactly op[2]==0: only mult/div ops in E create a hazard
  assign bus.stall = bus.d_mdu_use & (busy_s | (bus.start & ~bus.op[2]));
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

  // Result datapath for the op currently presented in E
  always_comb begin
    prod_s   = 64'd0;
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    case (bus.op)
      3'd0: begin
        prod_s   = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
      end
      3'd1: begin
        prod_s   = {32'd0, bus.a} * {32'd0, bus.b};
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
      end
      3'd2: begin
        if (bus.b == 32'd0) begin
          res_lo_s = 32'hFFFF_FFFF;
          res_hi_s = bus.a;
        end else if ((bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF)) begin
          res_lo_s = 32'h8000_0000;
          res_hi_s = 32'd0;
        end else begin
          res_lo_s = $signed(bus.a) / $signed(bus.b);
          res_hi_s = $signed(bus.a) % $signed(bus.b);
        end
      end
      3'd3: begin
        if (bus.b == 32'd0) begin
          res_lo_s = 32'hFFFF_FFFF;
          res_hi_s = bus.a;
        end else begin
          res_lo_s = bus.a / bus.b;
          res_hi_s = bus.a % bus.b;
        end
      end
      default: begin
        prod_s   = 64'd0;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
      end
    endcase
  end

  // Sequencer FSM: accept ops in IDLE, count down latency, commit HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      count_r      <= '0;
      done_r       <= 1'b0;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      pending_hi_r <= 32'd0;
      pending_lo_r <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            case (bus.op)
              3'd0, 3'd1: begin
                pending_hi_r <= res_hi_s;
                pending_lo_r <= res_lo_s;
                count_r      <= CW'(MULT_CYCLES - 1);
                state_r      <= MUL;
              end
              3'd2, 3'd3: begin
                pending_hi_r <= res_hi_s;
                pending_lo_r <= res_lo_s;
                count_r      <= CW'(DIV_CYCLES - 1);
                state_r      <= DIV;
              end
              3'd4:    hi_r <= bus.a;
              3'd5:    lo_r <= bus.a;
              default: state_r <= IDLE;
            endcase
          end
        end
        MUL, DIV: begin
          if (cancel_s) begin
            state_r <= IDLE;
            count_r <= '0;
          end else if (count_r != '0) begin
            count_r <= count_r - CW'(1);
          end else begin
            hi_r    <= pending_hi_r;
            lo_r    <= pending_lo_r;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= '0;
        end
      endcase
    end
  end

endmodule
